narnet_sequencer: RTL
=====================

Name: narnet_sequencer

Overview:
- Closed-loop scheduler for the NARNet inference core.
- Runs a multi-step forecast per job:
  - Open-loop warm-up: streams `warmup_len` seed samples from an upstream source into the core.
  - Closed-loop prediction: feeds each core output back as the next input for `horizon` predictions.
- Predictions go to a valid/ready output stream.
- Owns the core's enable and reset lines and its single-cycle `x_ready` / `out_ready` handshake; adds a watchdog on the core.

Parameters:
- N, 10, sample/prediction width (signed fixed point, format opaque to this block)
- TIMEOUT_CYC, 255, max cycles waiting for core `out_ready` before error (1..255)
- NN_RST_CYC, 2, cycles `nn_rst` is held high at job start (1..3)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- warmup_len  in  5  seed samples per job; 0 treated as 1
- horizon  in  8  closed-loop predictions per job
- s_valid  in  1  seed sample valid
- s_data  in  N  seed sample
- s_ready  out  1  seed accepted when s_valid&&s_ready
- nn_enable  out  1  core enable
- nn_rst  out  1  core reset (active-high)
- nn_x  out  N  core input sample
- nn_x_ready  out  1  one-cycle pulse: nn_x is valid
- nn_y  in  N  core output, held after out_ready
- nn_out_ready  in  1  one-cycle pulse: nn_y is valid
- p_valid  out  1  prediction valid
- p_data  out  N  prediction
- p_last  out  1  marks final prediction of job
- p_ready  in  1  downstream accepts prediction
- busy  out  1  high outside IDLE/DONE
- done  out  1  one-cycle pulse at normal job completion
- err_timeout  out  1  sticky watchdog error; cleared by next accepted start or rst_n

Behaviour:
- Single clock; all state changes on rising clk.
- rst_n low, next edge:
  - state=IDLE, counters=0.
  - nn_rst=1, nn_enable=0, nn_x=0, nn_x_ready=0.
  - s_ready=0, p_valid=0, p_data=0, p_last=0, busy=0, done=0, err_timeout=0.
  - Applies identically mid-job; any in-flight prediction is discarded.
- States: IDLE, NNRST, SEED, ISSUE, WAIT, EMIT, DONE, ERR.
- IDLE:
  - nn_rst=1, nn_enable=0.
  - start=1 → latch warmup_len (0→1) and horizon, clear err_timeout, goto NNRST.
  - start outside IDLE is ignored.
- NNRST:
  - nn_enable=1, nn_rst=1 for NN_RST_CYC cycles (reinitialises core tap delays).
  - Then nn_rst=0, goto SEED.
- SEED:
  - s_ready=1.
  - On s_valid&&s_ready: nn_x<=s_data, goto ISSUE.
  - s_ready is low in every other state.
- ISSUE:
  - nn_x_ready=1 for exactly one cycle.
  - Watchdog counter cleared; goto WAIT.
- WAIT:
  - Counter increments per cycle.
  - nn_out_ready=1:
    - During warm-up and not the last seed: discard nn_y, goto SEED.
    - Last seed or closed-loop step: if horizon==0 goto DONE; else p_data<=nn_y, p_valid<=1, p_last<=(emitted+1==horizon), goto EMIT.
  - Counter reaches TIMEOUT_CYC without nn_out_ready: err_timeout<=1, goto ERR.
  - If nn_out_ready arrives on the same edge the counter reaches TIMEOUT_CYC, the result wins.
- EMIT:
  - Hold p_valid/p_data/p_last stable until p_ready.
  - On acceptance: p_valid<=0, emitted++.
  - If p_last: goto DONE.
  - Else: nn_x<=p_data, goto ISSUE (feedback uses the accepted value, bit-exact).
  - Core is never issued while p_valid is high, so no output buffering beyond one register is needed.
- DONE:
  - done=1 for one cycle; goto IDLE.
- ERR:
  - nn_rst=1, p_valid=0; goto IDLE.
  - err_timeout stays high in IDLE.
  - done is not pulsed.
- busy=1 in NNRST, SEED, ISSUE, WAIT, EMIT, ERR.
- Arithmetic: no arithmetic on samples; nn_x and p_data are pass-through of s_data/nn_y.
  - emitted counter: 8-bit, never wraps (stops at horizon).
  - seed counter: 5-bit, up to 31.
- Per-job latency from start to first nn_x_ready: NN_RST_CYC + 2 cycles plus seed stall.
- Per-step overhead outside the core: 2 cycles (EMIT accept → ISSUE → WAIT).

Test Plan:
- Basic warm-up: warmup_len=3, horizon=0, seeds 0x060,0x070,0x080 with s_valid continuous, model core returning in+1 after 10 cycles → three nn_x_ready pulses with nn_x=0x060,0x070,0x080; no p_valid; done pulses once; busy falls with done.
- Closed loop: warmup_len=1, horizon=4, seed 0x010, same model → p_data 0x011,0x012,0x013,0x014; p_last only on 0x014; each nn_x equals previous accepted p_data.
- Backpressure: same as closed loop, p_ready low 20 cycles on 2nd prediction → p_data held at 0x012; no nn_x_ready while p_valid; sequence unchanged.
- Watchdog: TIMEOUT_CYC=16, core never answers → err_timeout=1 exactly 16 cycles after nn_x_ready; nn_rst=1; no done; next start clears err_timeout.
- Reset mid-job: rst_n low for 1 cycle during EMIT of 2nd prediction → next cycle all outputs at reset values (nn_rst=1, p_valid=0, busy=0); a new job then runs normally from seed.
- Edge config: warmup_len=0, horizon=1 → treated as 1 seed; exactly one prediction with p_last=1; start pulses while busy have no effect.

Source files
------------

// File: rtl/narnet_sequencer.sv
// Job scheduler for the NARNet inference core: seed warm-up from an upstream stream,
// then closed-loop prediction with each accepted output fed back, under a core watchdog.
module narnet_sequencer #(
  parameter int N           = 10,
  parameter int TIMEOUT_CYC = 255,
  parameter int NN_RST_CYC  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   warmup_len,
  input  logic [7:0]   horizon,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  output logic         nn_enable,
  output logic         nn_rst,
  output logic [N-1:0] nn_x,
  output logic         nn_x_ready,
  input  logic [N-1:0] nn_y,
  input  logic         nn_out_ready,
  output logic         p_valid,
  output logic [N-1:0] p_data,
  output logic         p_last,
  input  logic         p_ready,
  output logic         busy,
  output logic         done,
  output logic         err_timeout
);

  // state | meaning
  // IDLE  | waiting for start, core held in reset
  // NNRST | core enabled, reset held for NN_RST_CYC cycles
  // SEED  | accept one seed sample from the upstream stream
  // ISSUE | present nn_x to the core (one-cycle nn_x_ready)
  // WAIT  | wait for nn_out_ready under the watchdog
  // EMIT  | prediction held on p_* until accepted
  // DONE  | one-cycle done pulse
  // ERR   | watchdog expired, core back to reset
  typedef enum logic [2:0] {
    S_IDLE, S_NNRST, S_SEED, S_ISSUE, S_WAIT, S_EMIT, S_DONE, S_ERR
  } state_t;

  // The ISSUE cycle is the first watchdog cycle, so the error lands
  // TIMEOUT_CYC cycles after the nn_x_ready pulse.
  localparam logic [7:0] WD_LOAD  = 8'(TIMEOUT_CYC - 1);
  localparam logic [1:0] RST_LOAD = 2'(NN_RST_CYC - 1);

  state_t         state_q, state_d;
  logic [4:0]     wl_q, wl_d, seed_cnt_q, seed_cnt_d;
  logic [7:0]     hz_q, hz_d, emitted_q, emitted_d, wd_q, wd_d;
  logic [1:0]     rst_cnt_q, rst_cnt_d;
  logic [N-1:0]   nn_x_q, nn_x_d, p_data_q, p_data_d;
  logic           p_valid_q, p_valid_d, p_last_q, p_last_d, err_q, err_d;
  logic           last_pred;

  assign last_pred   = ({1'b0, emitted_q} + 9'd1) == {1'b0, hz_q};
  assign nn_x        = nn_x_q;
  assign p_data      = p_data_q;
  assign p_valid     = p_valid_q;
  assign p_last      = p_last_q;
  assign err_timeout = err_q;

  always_comb begin
    state_d    = state_q;
    wl_d       = wl_q;
    hz_d       = hz_q;
    seed_cnt_d = seed_cnt_q;
    emitted_d  = emitted_q;
    wd_d       = wd_q;
    rst_cnt_d  = rst_cnt_q;
    nn_x_d     = nn_x_q;
    p_data_d   = p_data_q;
    p_valid_d  = p_valid_q;
    p_last_d   = p_last_q;
    err_d      = err_q;
    s_ready    = 1'b0;
    nn_x_ready = 1'b0;
    nn_enable  = 1'b0;
    nn_rst     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        nn_rst = 1'b1;
        if (start) begin
          wl_d       = (warmup_len == 5'd0) ? 5'd1 : warmup_len;
          hz_d       = horizon;
          err_d      = 1'b0;
          seed_cnt_d = 5'd0;
          emitted_d  = 8'd0;
          rst_cnt_d  = RST_LOAD;
          state_d    = S_NNRST;
        end
      end
      S_NNRST: begin
        nn_enable = 1'b1;
        nn_rst    = 1'b1;
        busy      = 1'b1;
        if (rst_cnt_q == 2'd0) state_d = S_SEED;
        else                   rst_cnt_d = rst_cnt_q - 2'd1;
      end
      S_SEED: begin
        nn_enable = 1'b1;
        busy      = 1'b1;
        s_ready   = 1'b1;
        if (s_valid) begin
          nn_x_d     = s_data;
          seed_cnt_d = seed_cnt_q + 5'd1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        nn_enable  = 1'b1;
        busy       = 1'b1;
        nn_x_ready = 1'b1;
        wd_d       = WD_LOAD;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        nn_enable = 1'b1;
        busy      = 1'b1;
        // A result on the terminal cycle takes priority over the timeout.
        if (nn_out_ready) begin
          if (seed_cnt_q < wl_q) begin
            state_d = S_SEED;
          end else if (hz_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            p_data_d  = nn_y;
            p_valid_d = 1'b1;
            p_last_d  = last_pred;
            state_d   = S_EMIT;
          end
        end else if (wd_q <= 8'd1) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wd_d = wd_q - 8'd1;
        end
      end
      S_EMIT: begin
        nn_enable = 1'b1;
        busy      = 1'b1;
        if (p_ready) begin
          p_valid_d = 1'b0;
          p_last_d  = 1'b0;
          emitted_d = emitted_q + 8'd1;
          if (p_last_q) begin
            state_d = S_DONE;
          end else begin
            nn_x_d  = p_data_q;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        nn_rst    = 1'b1;
        busy      = 1'b1;
        p_valid_d = 1'b0;
        p_last_d  = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wl_q       <= '0;
      hz_q       <= '0;
      seed_cnt_q <= '0;
      emitted_q  <= '0;
      wd_q       <= '0;
      rst_cnt_q  <= '0;
      nn_x_q     <= '0;
      p_data_q   <= '0;
      p_valid_q  <= 1'b0;
      p_last_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wl_q       <= wl_d;
      hz_q       <= hz_d;
      seed_cnt_q <= seed_cnt_d;
      emitted_q  <= emitted_d;
      wd_q       <= wd_d;
      rst_cnt_q  <= rst_cnt_d;
      nn_x_q     <= nn_x_d;
      p_data_q   <= p_data_d;
      p_valid_q  <= p_valid_d;
      p_last_q   <= p_last_d;
      err_q      <= err_d;
    end
  end

endmodule
